// File: rtl/layer_serializer.sv
// -----------------------------------------------------------------------------
// layer_serializer
//
// Collects the NN per-neuron results of a fully-connected layer, each arriving
// with its own one-cycle valid pulse, and once every neuron has reported,
// replays them one word per cycle (neuron 0 first) as the serial x_valid/x_in
// stream for the next layer.
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous, active-low reset
//   in_valid     [NN]            per-neuron result-valid pulses
//   in_data      [NN*dataWidth]  neuron i result at [i*dataWidth +: dataWidth]
//   clr_overrun  synchronous clear of the sticky overrun flag
//   out_valid    serial word valid
//   out_data     [dataWidth]     serial word, holds when out_valid is low
//   busy         high while a frame is being shifted out
//   overrun      sticky protocol-error flag (repeat pulse, or pulse during shift)
//
// Optional build macro LAYER_SER_MAXOUT_EN adds:
//   max_idx      [$clog2(NN)]    argmax (signed, ties -> lower index) of the frame
//   max_valid    one-cycle pulse in the cycle after the last word
// -----------------------------------------------------------------------------
module layer_serializer #(
    parameter int NN        = 30,
    parameter int dataWidth = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NN-1:0]             in_valid,
    input  logic [NN*dataWidth-1:0]   in_data,
    input  logic                      clr_overrun,
    output logic                      out_valid,
    output logic [dataWidth-1:0]      out_data,
    output logic                      busy,
    output logic                      overrun
`ifdef LAYER_SER_MAXOUT_EN
    ,
    output logic [$clog2(NN)-1:0]     max_idx,
    output logic                      max_valid
`endif
);

    localparam int CW = $clog2(NN);

    typedef enum logic {COLLECT, SHIFT} state_e;

    state_e                 state_q, state_d;
    logic [NN-1:0]          mask_q, mask_d;
    logic [CW-1:0]          count_q, count_d;
    logic                   out_valid_q, out_valid_d;
    logic [dataWidth-1:0]   out_data_q, out_data_d;
    logic                   busy_q, busy_d;
    logic                   overrun_q, overrun_d;
    logic [dataWidth-1:0]   buf_q [NN];

    logic                   frame_done;
    logic                   last_word;
    logic                   set_ovr;

    // The completing edge counts data arriving on that same edge.
    assign frame_done = (state_q == COLLECT) && (&(mask_q | in_valid));
    assign last_word  = (count_q == CW'(NN - 1));

    // NOTE: the word buffer has no reset; every entry is rewritten before a
    // frame can start, so resetting it would only cost flops and routing.
    always_ff @(posedge clk) begin
        if (state_q == COLLECT) begin
            for (int i = 0; i < NN; i++) begin
                if (in_valid[i]) buf_q[i] <= in_data[i*dataWidth +: dataWidth];
            end
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= COLLECT;
            mask_q      <= '0;
            count_q     <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            busy_q      <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            mask_q      <= mask_d;
            count_q     <= count_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            busy_q      <= busy_d;
            overrun_q   <= overrun_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            COLLECT: if (frame_done) state_d = SHIFT;
            SHIFT:   if (last_word)  state_d = COLLECT;
            default: state_d = COLLECT;
        endcase
    end

    // Output / datapath logic
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned, which would infer a latch.
    always_comb begin
        mask_d      = mask_q;
        count_d     = count_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        busy_d      = busy_q;
        set_ovr     = 1'b0;
        case (state_q)
            COLLECT: begin
                mask_d  = mask_q | in_valid;
                set_ovr = |(in_valid & mask_q);
                if (frame_done) begin
                    mask_d      = '0;
                    count_d     = '0;
                    out_valid_d = 1'b1;
                    busy_d      = 1'b1;
                    // Word 0 may be landing in the buffer on this very edge.
                    out_data_d  = in_valid[0] ? in_data[dataWidth-1:0] : buf_q[0];
                end
            end
            SHIFT: begin
                set_ovr = |in_valid;
                if (last_word) begin
                    out_valid_d = 1'b0;
                    busy_d      = 1'b0;
                end else begin
                    count_d    = count_q + CW'(1);
                    out_data_d = buf_q[count_q + CW'(1)];
                end
            end
            default: ;
        endcase
        // Set has priority over clear.
        overrun_d = set_ovr ? 1'b1 : (clr_overrun ? 1'b0 : overrun_q);
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign busy      = busy_q;
    assign overrun   = overrun_q;

`ifdef LAYER_SER_MAXOUT_EN
    logic [dataWidth-1:0] run_max_q, run_max_d;
    logic [CW-1:0]        run_idx_q, run_idx_d;
    logic [CW-1:0]        max_idx_q, max_idx_d;
    logic                 max_valid_q, max_valid_d;
    logic                 take_cur;

    // The word currently on out_data is index count_q; strict '>' keeps the
    // lower index on ties.
    assign take_cur = (count_q == '0) || ($signed(out_data_q) > $signed(run_max_q));

    always_comb begin
        run_max_d   = run_max_q;
        run_idx_d   = run_idx_q;
        max_idx_d   = max_idx_q;
        max_valid_d = 1'b0;
        if (state_q == SHIFT) begin
            if (take_cur) begin
                run_max_d = out_data_q;
                run_idx_d = count_q;
            end
            if (last_word) begin
                max_valid_d = 1'b1;
                max_idx_d   = take_cur ? count_q : run_idx_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            run_max_q   <= '0;
            run_idx_q   <= '0;
            max_idx_q   <= '0;
            max_valid_q <= 1'b0;
        end else begin
            run_max_q   <= run_max_d;
            run_idx_q   <= run_idx_d;
            max_idx_q   <= max_idx_d;
            max_valid_q <= max_valid_d;
        end
    end

    assign max_idx   = max_idx_q;
    assign max_valid = max_valid_q;
`endif

endmodule

// File: tb/tb_layer_serializer.sv
// -----------------------------------------------------------------------------
// tb_layer_serializer
//
// Scoreboard bench for layer_serializer (NN=30, dataWidth=16). Stimulus pushes
// the expected serial words into exp_q; a negedge monitor pops and compares
// each word the DUT presents and checks that busy tracks out_valid.
// -----------------------------------------------------------------------------
module tb_layer_serializer;

    localparam int NN = 30;
    localparam int W  = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NN-1:0]     in_valid = '0;
    logic [NN*W-1:0]   in_data = '0;
    logic              clr_overrun = 1'b0;
    logic              out_valid;
    logic [W-1:0]      out_data;
    logic              busy;
    logic              overrun;
`ifdef LAYER_SER_MAXOUT_EN
    logic [$clog2(NN)-1:0] max_idx;
    logic                  max_valid;
`endif

    int n_checks = 0;
    int n_errors = 0;
    logic [W-1:0] exp_q [$];

    always #5 clk = ~clk;

    layer_serializer #(.NN(NN), .dataWidth(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .clr_overrun (clr_overrun),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .busy        (busy),
        .overrun     (overrun)
`ifdef LAYER_SER_MAXOUT_EN
        ,
        .max_idx     (max_idx),
        .max_valid   (max_valid)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every presented word must match the head of the scoreboard.
    always @(negedge clk) begin
        if (rst) begin
            check("busy_mirrors_valid", 32'(busy), 32'(out_valid));
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_word: got %0h expected no word", out_data);
                end else begin
                    logic [W-1:0] e;
                    e = exp_q.pop_front();
                    check("word", 32'(out_data), 32'(e));
                end
            end
        end
    end

    // Drive one cycle of pulses; returns at the negedge after the capture edge.
    task automatic drive(input logic [NN-1:0] v, input logic [NN*W-1:0] d);
        @(negedge clk);
        in_valid = v;
        in_data  = d;
        @(negedge clk);
        in_valid = '0;
    endtask

    // Wait (bounded) for the scoreboard to empty, then expect the stream idle.
    task automatic drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check({name, "_drained"}, 32'(exp_q.size()), 32'd0);
        @(negedge clk);
        check({name, "_idle_valid"}, 32'(out_valid), 32'd0);
        check({name, "_idle_busy"}, 32'(busy), 32'd0);
    endtask

    task automatic clear_overrun();
        @(negedge clk);
        clr_overrun = 1'b1;
        @(negedge clk);
        clr_overrun = 1'b0;
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [NN*W-1:0] d;
        logic [NN-1:0]   v;

        // ---------------- reset state
        #2 rst = 1'b0;
        #20;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
`ifdef LAYER_SER_MAXOUT_EN
        check("rst_max_idx", 32'(max_idx), 32'd0);
        check("rst_max_valid", 32'(max_valid), 32'd0);
`endif
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // ---------------- all pulses together, slice i = 3*i
        for (int i = 0; i < NN; i++) begin
            d[i*W +: W] = W'(3 * i);
            exp_q.push_back(W'(3 * i));
        end
        drive('1, d);
        check("t1_first_cycle_valid", 32'(out_valid), 32'd1);
        drain("t1");
        check("t1_overrun", 32'(overrun), 32'd0);

        // ---------------- staggered arrival: 0..14 then 15..29 five cycles later
        for (int i = 0; i < NN; i++) d[i*W +: W] = W'(16'h0100 + i);
        drive(NN'(32'h0000_7FFF), d);
        repeat (4) begin
            @(negedge clk);
            check("t2_no_early_output", 32'(out_valid), 32'd0);
        end
        for (int i = 0; i < NN; i++) exp_q.push_back(W'(16'h0100 + i));
        drive(~NN'(32'h0000_7FFF), d);
        check("t2_first_cycle_valid", 32'(out_valid), 32'd1);
        drain("t2");

        // ---------------- repeat pulse on neuron 4: latest wins, overrun sets
        d = '0;
        d[4*W +: W] = 16'h0011;
        drive(NN'(32'h10), d);
        check("t3_no_overrun_first", 32'(overrun), 32'd0);
        d[4*W +: W] = 16'h0022;
        drive(NN'(32'h10), d);
        check("t3_overrun_set", 32'(overrun), 32'd1);
        for (int i = 0; i < NN; i++) begin
            if (i != 4) d[i*W +: W] = W'(16'h0200 + i);
            exp_q.push_back((i == 4) ? 16'h0022 : W'(16'h0200 + i));
        end
        v = '1;
        v[4] = 1'b0;
        drive(v, d);
        drain("t3");
        check("t3_overrun_sticky", 32'(overrun), 32'd1);
        clear_overrun();
        check("t3_overrun_cleared", 32'(overrun), 32'd0);

        // ---------------- pulse during SHIFT is ignored and flags overrun
        for (int i = 0; i < NN; i++) begin
            d[i*W +: W] = W'(16'h0300 + i);
            exp_q.push_back(W'(16'h0300 + i));
        end
        drive('1, d);
        repeat (3) @(negedge clk);
        d[7*W +: W] = 16'hFFFF;
        drive(NN'(32'h80), d);
        check("t4_overrun_in_shift", 32'(overrun), 32'd1);
        drain("t4");
        // Next frame must need all 30 again, including neuron 7.
        for (int i = 0; i < NN; i++) d[i*W +: W] = W'(16'h0400 + i);
        v = '1;
        v[7] = 1'b0;
        drive(v, d);
        repeat (3) begin
            @(negedge clk);
            check("t4_waits_for_bit7", 32'(out_valid), 32'd0);
        end
        for (int i = 0; i < NN; i++) exp_q.push_back(W'(16'h0400 + i));
        drive(NN'(32'h80), d);
        drain("t4b");
        clear_overrun();
        check("t4_overrun_cleared", 32'(overrun), 32'd0);

        // ---------------- async reset at word 10
        for (int i = 0; i < NN; i++) begin
            d[i*W +: W] = W'(16'h0500 + i);
            exp_q.push_back(W'(16'h0500 + i));
        end
        drive('1, d);
        repeat (10) @(negedge clk);
        #1 rst = 1'b0;
        #1;
        check("t5_rst_valid", 32'(out_valid), 32'd0);
        check("t5_rst_busy", 32'(busy), 32'd0);
        check("t5_rst_data", 32'(out_data), 32'd0);
        check("t5_words_left", 32'(exp_q.size()), 32'd19);
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("t5_quiet_after_rst", 32'(out_valid), 32'd0);
        end
        for (int i = 0; i < NN; i++) begin
            d[i*W +: W] = W'(16'h0600 + i);
            exp_q.push_back(W'(16'h0600 + i));
        end
        drive('1, d);
        drain("t5");

`ifdef LAYER_SER_MAXOUT_EN
        // ---------------- argmax: slice i = -100+i, slices 12 and 20 = 0x0050
        for (int i = 0; i < NN; i++) begin
            d[i*W +: W] = W'(-100 + i);
            if (i == 12 || i == 20) d[i*W +: W] = 16'h0050;
            exp_q.push_back(d[i*W +: W]);
        end
        drive('1, d);   // now in cycle T+1
        repeat (29) begin
            @(negedge clk);
            check("t6_no_early_max", 32'(max_valid), 32'd0);
        end
        @(negedge clk);   // cycle T+31
        check("t6_max_valid", 32'(max_valid), 32'd1);
        check("t6_max_idx", 32'(max_idx), 32'd12);
        @(negedge clk);
        check("t6_max_pulse_one", 32'(max_valid), 32'd0);
        check("t6_max_idx_hold", 32'(max_idx), 32'd12);
        check("t6_drained", 32'(exp_q.size()), 32'd0);
`endif

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
